pump_driver: RTL

- Actuator-side end of the pump alternation loop.
- Takes the pump selection `use_pump` from the pump controller plus a level `demand` request.
- Drives the two pump enables with minimum-run and cool-down timing.
- Reports the last-activated pump back to the controller on B1/B2, closing the loop so successive activations alternate.

---
 rtl/pump_pkg.sv | 15 +
 rtl/pump_timer.sv | 38 +++
 rtl/pump_driver.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pump_pkg.sv
// Shared definitions for the pump alternation loop (driver and controller).
//   pump_state_e : driver FSM encoding (ST_IDLE / ST_RUN / ST_COOL)
//   PUMP_1/PUMP_2: pump select values carried on use_pump and sel
package pump_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_COOL = 2'd2
   } pump_state_e;

   localparam logic PUMP_1 = 1'b0;
   localparam logic PUMP_2 = 1'b1;

endpackage

// File: rtl/pump_timer.sv
// Clearable saturating up-counter with terminal compare.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   clr_i  : synchronous clear to zero (has priority over counting)
//   lim_i  : saturation / terminal value
//   term_o : count equals lim_i
module pump_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic [CNT_W-1:0] lim_i,
   output logic             term_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_q != lim_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term_o = (cnt_q == lim_i);

endmodule

// File: rtl/pump_driver.sv
// Actuator-side pump driver: starts the pump chosen by the controller on demand,
// enforces a minimum run time and a post-stop cool-down, and reports the last
// started pump on B1/B2 so the controller can alternate.
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   demand   : level request for pumping
//   use_pump : controller selection (PUMP_1 / PUMP_2), sampled on start only
//   pump1_en, pump2_en : registered pump enables, never both high
//   B1, B2   : registered one-hot "last started pump" level
//   busy     : FSM not in ST_IDLE
// Optional build macro PUMP_FAULT_EN adds pump1_fault/pump2_fault inputs and a
// registered fault output (failover on start, forced stop on running-pump fault).
module pump_driver
   import pump_pkg::*;
#(
   parameter int unsigned MIN_ON   = 4,
   parameter int unsigned COOLDOWN = 3,
   parameter int unsigned CNT_W    = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic demand,
   input  logic use_pump,
`ifdef PUMP_FAULT_EN
   input  logic pump1_fault,
   input  logic pump2_fault,
   output logic fault,
`endif
   output logic pump1_en,
   output logic pump2_en,
   output logic B1,
   output logic B2,
   output logic busy
);

   localparam logic [CNT_W-1:0] RunLim  = CNT_W'(MIN_ON - 1);
   // COOL is never entered when COOLDOWN is 0, so the limit value is then don't-care
   localparam logic [CNT_W-1:0] CoolLim = (COOLDOWN > 0) ? CNT_W'(COOLDOWN - 1) : '0;
   localparam pump_state_e      StopTo  = (COOLDOWN > 0) ? ST_COOL : ST_IDLE;

   pump_state_e state_q, state_d;
   logic        sel_q, sel_d;
   logic        p1_q, p1_d, p2_q, p2_d;
   logic        b1_q, b1_d, b2_q, b2_d;
   logic        f1, f2;
   logic        req_bad, alt_bad, run_bad, pick;
   logic        tmr_clr, tmr_term;
   logic [CNT_W-1:0] tmr_lim;

`ifdef PUMP_FAULT_EN
   logic fault_q, fault_d;
   assign f1    = pump1_fault;
   assign f2    = pump2_fault;
   assign fault = fault_q;
`else
   assign f1 = 1'b0;
   assign f2 = 1'b0;
`endif

   assign req_bad = (use_pump == PUMP_2) ? f2 : f1;
   assign alt_bad = (use_pump == PUMP_2) ? f1 : f2;
   assign run_bad = (sel_q == PUMP_2) ? f2 : f1;
   // Fall back to the other pump only when the requested one is faulted
   assign pick    = req_bad ? ~use_pump : use_pump;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      b1_d    = b1_q;
      b2_d    = b2_q;
      tmr_lim = RunLim;
`ifdef PUMP_FAULT_EN
      fault_d = fault_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (demand) begin
               if (!(req_bad && alt_bad)) begin
                  state_d = ST_RUN;
                  sel_d   = pick;
                  p1_d    = (pick == PUMP_1);
                  p2_d    = (pick == PUMP_2);
                  b1_d    = (pick == PUMP_1);
                  b2_d    = (pick == PUMP_2);
`ifdef PUMP_FAULT_EN
                  fault_d = 1'b0;
`endif
               end else begin
`ifdef PUMP_FAULT_EN
                  fault_d = 1'b1;
`endif
               end
            end
         end
         ST_RUN: begin
            tmr_lim = RunLim;
            if ((tmr_term && !demand) || run_bad) begin
               state_d = StopTo;
               p1_d    = 1'b0;
               p2_d    = 1'b0;
`ifdef PUMP_FAULT_EN
               if (run_bad) fault_d = 1'b1;
`endif
            end
         end
         ST_COOL: begin
            tmr_lim = CoolLim;
            if (tmr_term) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            p1_d    = 1'b0;
            p2_d    = 1'b0;
         end
      endcase
   end

   // Timer restarts from zero on every state entry and idles at zero
   assign tmr_clr = (state_q == ST_IDLE) || (state_d != state_q);

   pump_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk_i  (clk),
      .rst_ni (reset),
      .clr_i  (tmr_clr),
      .lim_i  (tmr_lim),
      .term_o (tmr_term)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         sel_q   <= PUMP_1;
         p1_q    <= 1'b0;
         p2_q    <= 1'b0;
         b1_q    <= 1'b0;
         b2_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         b1_q    <= b1_d;
         b2_q    <= b2_d;
      end
   end

`ifdef PUMP_FAULT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end
`endif

   assign pump1_en = p1_q;
   assign pump2_en = p2_q;
   assign B1       = b1_q;
   assign B2       = b2_q;
   assign busy     = (state_q != ST_IDLE);

endmodule
